mult_result_collector: RTL and testbench

//   Downstream companion of the 4-stage add-multiply pipeline (result = (a+b)*c, 17 bit).

---
 rtl/mult_result_collector.sv | 77 +++++++
 tb/tb_mult_result_collector.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/mult_result_collector.sv
// Result collector for the 4-stage (a+b)*c multiplier. It tracks which issue slots carry real
// operands, captures their results, and buffers them toward a valid/ready consumer.
module mult_result_collector #(
  parameter int DATA_W  = 17,
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [DATA_W-1:0] mult_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy,
  output logic              proto_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int SUM_W = CNT_W + 1;

  logic [LATENCY-1:0] vld_sr;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               accept;
  logic               wr_en;
  logic               pop;

  function automatic logic [SUM_W-1:0] popcount(input logic [LATENCY-1:0] v);
    logic [SUM_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < LATENCY; i++) cnt = cnt + SUM_W'(v[i]);
    return cnt;
  endfunction

  // Credit covers both buffered entries and results still inside the multiplier, so every
  // accepted issue is guaranteed a FIFO slot. Depends on registers only.
  assign issue_ready = (SUM_W'(occupancy) + popcount(vld_sr)) < SUM_W'(DEPTH);
  assign accept      = issue_valid && issue_ready;
  assign wr_en       = vld_sr[LATENCY-1];
  assign out_valid   = (occupancy != '0);
  assign pop         = out_valid && out_ready;
  assign out_data    = out_valid ? mem[rd_ptr] : '0;

  // Stage: slot tracking, pointers, occupancy, sticky protocol error
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_sr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      proto_err <= 1'b0;
    end else begin
      vld_sr <= {vld_sr[LATENCY-2:0], accept};
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
      if (issue_valid && !issue_ready) proto_err <= 1'b1;
    end
  end

  // Stage: result storage; data path is not reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= mult_result;
  end

  no_write_when_full: assert property (@(posedge clk) disable iff (rst)
    wr_en |-> (occupancy != CNT_W'(DEPTH)));

endmodule

// File: tb/tb_mult_result_collector.sv
// Bench for mult_result_collector: a behavioural multiplier feeds the DUT and a queue-based
// reference model predicts every output cycle by cycle.
module tb_mult_result_collector;

  localparam int DATA_W  = 17;
  localparam int LATENCY = 4;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic              issue_ready;
  logic [DATA_W-1:0] mult_result;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  occupancy;
  logic              proto_err;
  logic [7:0]        a, b, c;
  logic [DATA_W-1:0] mp [LATENCY];

  mult_result_collector #(.DATA_W(DATA_W), .LATENCY(LATENCY), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .mult_result(mult_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .occupancy(occupancy), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  // Stand-in for the add-multiply pipeline: computes every cycle, no valid, reset from ~rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) mp[i] <= '0;
    end else begin
      mp[0] <= DATA_W'((a + 17'd0 + b) * c);
      for (int i = 1; i < LATENCY; i++) mp[i] <= mp[i-1];
    end
  end
  assign mult_result = mp[LATENCY-1];

  typedef struct { int val; int cap; } op_t;
  op_t m_infl[$];
  int  m_fifo[$];
  bit  m_err;
  int  cyc;
  int  n_checks = 0;
  int  n_pass   = 0;
  int  acc_cnt;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic bit m_ready();
    return (m_fifo.size() + m_infl.size()) < DEPTH;
  endfunction

  function automatic void m_clear();
    m_infl.delete();
    m_fifo.delete();
    m_err = 1'b0;
  endfunction

  // One cycle: drive at negedge, check just after, then advance the model to the next cycle.
  task automatic cycle(input bit iv, input bit ordy, input int ia, input int ib, input int ic);
    bit exp_valid;
    issue_valid = iv; out_ready = ordy;
    a = 8'(ia); b = 8'(ib); c = 8'(ic);
    #1;
    exp_valid = (m_fifo.size() != 0);
    chk("issue_ready", int'(issue_ready), int'(m_ready()));
    chk("out_valid",   int'(out_valid),   int'(exp_valid));
    chk("out_data",    int'(out_data),    exp_valid ? m_fifo[0] : 0);
    chk("occupancy",   int'(occupancy),   m_fifo.size());
    chk("proto_err",   int'(proto_err),   int'(m_err));
    if (iv && issue_ready) acc_cnt++;
    if (exp_valid && ordy) void'(m_fifo.pop_front());
    while (m_infl.size() != 0 && m_infl[0].cap == cyc) m_fifo.push_back(m_infl.pop_front().val);
    if (iv && m_ready()) begin
      op_t op;
      op.val = (ia + ib) * ic;
      op.cap = cyc + LATENCY;
      m_infl.push_back(op);
    end else if (iv) begin
      m_err = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic rnd_cycle(input bit iv, input bit ordy);
    cycle(iv, ordy, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) rnd_cycle(1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c = '0;
    cyc = 0; acc_cnt = 0;
    m_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_issue_ready", int'(issue_ready), 1);
    chk("rst_out_valid",   int'(out_valid),   0);
    chk("rst_out_data",    int'(out_data),    0);
    chk("rst_occupancy",   int'(occupancy),   0);
    chk("rst_proto_err",   int'(proto_err),   0);
    @(negedge clk);
    rst = 1'b0;

    // single operation, result 56 five cycles later
    cycle(1'b1, 1'b1, 3, 5, 7);
    drain(8);

    // half-full FIFO, then streaming with concurrent push/pop across pointer wrap
    for (int i = 0; i < 4; i++) rnd_cycle(1'b1, 1'b0);
    for (int i = 0; i < 5; i++) rnd_cycle(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) rnd_cycle(m_ready(), 1'b1);
    drain(10);

    // extreme operands
    cycle(1'b1, 1'b1, 255, 255, 255);
    cycle(1'b1, 1'b1, 0, 0, 0);
    drain(8);

    // fill with consumer stalled; excess issues are protocol errors and get dropped
    acc_cnt = 0;
    for (int i = 0; i < 14; i++) rnd_cycle(1'b1, 1'b0);
    chk("accepts_when_stalled", acc_cnt, DEPTH);
    for (int i = 0; i < 3; i++) rnd_cycle(1'b0, 1'b0);
    drain(14);

    // reset with 4 buffered and 3 in flight
    for (int i = 0; i < 7; i++) rnd_cycle(1'b1, 1'b0);
    rnd_cycle(1'b0, 1'b0);
    issue_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_clear();
    chk("mid_rst_out_valid",   int'(out_valid),   0);
    chk("mid_rst_occupancy",   int'(occupancy),   0);
    chk("mid_rst_issue_ready", int'(issue_ready), 1);
    chk("mid_rst_proto_err",   int'(proto_err),   0);
    @(negedge clk);
    rst = 1'b0;
    drain(8);

    // randomized legal traffic with random back-pressure
    for (int i = 0; i < 300; i++) rnd_cycle(($urandom_range(0, 3) != 0) && m_ready(), $urandom_range(0, 2) != 0);
    drain(14);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
